// File: rtl/lvt_regfile_2w4r.sv
// 2-write/4-read register file: two banks of four 1w1r copies, selected per read by a Live Value Table.
// Reads are combinational (0 cycles); writes are visible the cycle after the sampling edge; no backpressure.
module lvt_regfile_2w4r #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  we_0,
   input  logic [ADDR_WIDTH-1:0] write_addr_0,
   input  logic [DATA_WIDTH-1:0] write_data_0,
   input  logic                  we_1,
   input  logic [ADDR_WIDTH-1:0] write_addr_1,
   input  logic [DATA_WIDTH-1:0] write_data_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_0,
   input  logic [ADDR_WIDTH-1:0] read_addr_1,
   input  logic [ADDR_WIDTH-1:0] read_addr_2,
   input  logic [ADDR_WIDTH-1:0] read_addr_3,
   output logic [DATA_WIDTH-1:0] read_data_0,
   output logic [DATA_WIDTH-1:0] read_data_1,
   output logic [DATA_WIDTH-1:0] read_data_2,
   output logic [DATA_WIDTH-1:0] read_data_3,
   output logic                  write_conflict
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DEPTH-1:0]      lvt;
   logic [ADDR_WIDTH-1:0] read_addr [4];
   logic [DATA_WIDTH-1:0] read_data [4];

   assign read_addr[0] = read_addr_0;
   assign read_addr[1] = read_addr_1;
   assign read_addr[2] = read_addr_2;
   assign read_addr[3] = read_addr_3;

   assign read_data_0 = read_data[0];
   assign read_data_1 = read_data[1];
   assign read_data_2 = read_data[2];
   assign read_data_3 = read_data[3];

   // One copy per read port in each bank; bank contents are deliberately never reset.
   for (genvar n = 0; n < 4; n++) begin : g_copy
      logic [DATA_WIDTH-1:0] bank0 [DEPTH];
      logic [DATA_WIDTH-1:0] bank1 [DEPTH];

      always_ff @(posedge clock) begin
         if (we_0) bank0[write_addr_0] <= write_data_0;
         if (we_1) bank1[write_addr_1] <= write_data_1;
      end

      assign read_data[n] = lvt[read_addr[n]] ? bank1[read_addr[n]] : bank0[read_addr[n]];
   end

   // Port 1 assignment comes last so it wins a same-address dual write.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lvt <= '0;
      end else begin
         if (we_0) lvt[write_addr_0] <= 1'b0;
         if (we_1) lvt[write_addr_1] <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) write_conflict <= 1'b0;
      else       write_conflict <= we_0 & we_1 & (write_addr_0 == write_addr_1);
   end

endmodule
